// File: rtl/alu_result_stage_if.sv
// Bundle of the ALU-result ingress handshake, the datapath bus beat handshake
// and the architectural HI/LO / bad-op status outputs of alu_result_stage.
// The master side is the environment (ALU + bus consumer); the slave side is the stage.
interface alu_result_stage_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] c_lo_in;
    logic [DATA_W-1:0] c_hi_in;
    logic [3:0]        ctrl_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_is_hi;
    logic              bus_last;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              bad_op;

    modport master (
        output c_lo_in, c_hi_in, ctrl_in, in_valid, bus_ready,
        input  in_ready, bus_data, bus_valid, bus_is_hi, bus_last,
               hi_out, lo_out, bad_op
    );

    modport slave (
        input  c_lo_in, c_hi_in, ctrl_in, in_valid, bus_ready,
        output in_ready, bus_data, bus_valid, bus_is_hi, bus_last,
               hi_out, lo_out, bad_op
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers up to two ALU results, commits mul/div results to
// the architectural HI/LO registers and serialises each buffered result onto
// the datapath bus (one LO beat, or LO then HI for mul/div).
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_stage_if.slave    io
);

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } beat_state_e;

    // Z buffer storage, indexed by 1-bit wrapping pointers
    logic [DATA_W-1:0] loMem_q   [DEPTH];
    logic [DATA_W-1:0] hiMem_q   [DEPTH];
    logic [3:0]        ctrlMem_q [DEPTH];

    logic              wrPtr_q;
    logic              rdPtr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    beat_state_e       beatState_q;

    logic [DATA_W-1:0] archHi_q;
    logic [DATA_W-1:0] archLo_q;
    logic              badOp_q;

    logic              accept;
    logic              inIsMulDiv;
    logic              inIsBadOp;
    logic              push;
    logic              pop;
    logic              headIsMulDiv;
    logic [3:0]        headCtrl;

    // Handshake decode and occupancy next-state; push/pop together only at count 1
    always_comb begin
        headCtrl     = ctrlMem_q[rdPtr_q];
        headIsMulDiv = (headCtrl == 4'd10) || (headCtrl == 4'd11);
        inIsMulDiv   = (io.ctrl_in == 4'd10) || (io.ctrl_in == 4'd11);
        inIsBadOp    = (io.ctrl_in[3:2] == 2'b11);
        accept       = io.in_valid && io.in_ready;
        push         = accept && !inIsBadOp;
        pop          = io.bus_valid && io.bus_ready &&
                       ((beatState_q == S_HI) || !headIsMulDiv);
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Bus beat view of the head entry; forced quiet while the buffer is empty
    always_comb begin
        io.in_ready  = (count_q < 2'd2);
        io.bus_valid = (count_q != 2'd0);
        io.bus_data  = '0;
        io.bus_is_hi = 1'b0;
        io.bus_last  = 1'b0;
        if (io.bus_valid) begin
            io.bus_data  = (beatState_q == S_HI) ? hiMem_q[rdPtr_q] : loMem_q[rdPtr_q];
            io.bus_is_hi = (beatState_q == S_HI);
            io.bus_last  = (beatState_q == S_HI) || !headIsMulDiv;
        end
        io.hi_out = archHi_q;
        io.lo_out = archLo_q;
        io.bad_op = badOp_q;
    end

    // Buffer, pointers, beat FSM, HI/LO commit and bad-op pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                loMem_q[i]   <= '0;
                hiMem_q[i]   <= '0;
                ctrlMem_q[i] <= '0;
            end
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            count_q     <= 2'd0;
            beatState_q <= S_LO;
            archHi_q    <= '0;
            archLo_q    <= '0;
            badOp_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            badOp_q <= accept && inIsBadOp;

            if (push) begin
                loMem_q[wrPtr_q]   <= io.c_lo_in;
                hiMem_q[wrPtr_q]   <= inIsMulDiv ? io.c_hi_in : '0;
                ctrlMem_q[wrPtr_q] <= io.ctrl_in;
                wrPtr_q            <= ~wrPtr_q;
            end

            if (accept && inIsMulDiv) begin
                archLo_q <= io.c_lo_in;
                archHi_q <= io.c_hi_in;
            end

            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end

            case (beatState_q)
                S_LO: begin
                    if (io.bus_valid && io.bus_ready && headIsMulDiv) begin
                        beatState_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (io.bus_ready) begin
                        beatState_q <= S_LO;
                    end
                end
                default: beatState_q <= S_LO;
            endcase
        end
    end

endmodule
